sa_score_collector: RTL and testbench

Downstream stage of the attention systolic-array path. It collects the Q·K^T partial-result rows streamed out of the systolic array, tile by tile, and scales each element by 1/sqrt(d_k) with an arithmetic right shift. It writes the results into a registered DIM×DIM score matrix for the softmax stage. A tile counter, a row handshake and a done flag frame one full score-matrix pass.

---
 rtl/sa_score_collector.sv | 93 +++++++++
 tb/tb_sa_score_collector.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sa_score_collector.sv
// sa_score_collector: gathers systolic-array tile rows into a scaled DIM x DIM score matrix.
// Define SCORE_ROUND_EN to round half-up when scaling; otherwise the shift floors.
module sa_score_collector #(
   parameter int D_W   = 16,
   parameter int SA_R  = 16,
   parameter int SA_C  = 16,
   parameter int DIM   = 64,
   parameter int SHIFT = 3
) (
   input  logic                    I_CLK,
   input  logic                    I_ASYN_RST,
   input  logic                    I_START,
   input  logic                    I_ROW_VLD,
   input  logic [SA_C*D_W-1:0]     I_ROW,
   output logic                    O_ROW_RDY,
   output logic                    O_TILE_DONE,
   output logic                    O_DATA_VLD,
   output logic [DIM*DIM*D_W-1:0]  O_SCORE
);
   localparam int TC = DIM / SA_C;
   localparam int TR = DIM / SA_R;
   localparam int RW = SA_R > 1 ? $clog2(SA_R) : 1;
   localparam int CW = TC > 1 ? $clog2(TC) : 1;
   localparam int TW = TR > 1 ? $clog2(TR) : 1;
`ifdef SCORE_ROUND_EN
   localparam logic signed [D_W:0] RND = (D_W+1)'(2 ** (SHIFT - 1));
`else
   localparam logic signed [D_W:0] RND = '0;
`endif

   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

   state_t state, state_nxt;
   logic [RW-1:0] row_cnt;
   logic [CW-1:0] tile_c;
   logic [TW-1:0] tile_r;
   logic [SA_C*D_W-1:0] scaled;
   logic accept, row_last, tc_last, tr_last;
   int wr_base;

   // Sign-extend one bit so the rounding add cannot overflow before the shift
   for (genvar j = 0; j < SA_C; j++) begin : g_scale
      logic signed [D_W:0] ext;
      assign ext = {I_ROW[j*D_W+D_W-1], I_ROW[j*D_W +: D_W]};
      assign scaled[j*D_W +: D_W] = D_W'((ext + RND) >>> SHIFT);
   end

   assign O_ROW_RDY  = state == COLLECT;
   assign O_DATA_VLD = state == DONE;
   assign accept     = I_ROW_VLD && O_ROW_RDY && !I_START;
   assign row_last   = row_cnt == RW'(SA_R - 1);
   assign tc_last    = tile_c == CW'(TC - 1);
   assign tr_last    = tile_r == TW'(TR - 1);

   always_comb begin
      state_nxt = I_START ? COLLECT : (accept && row_last && tc_last && tr_last) ? DONE : state;
      wr_base   = (int'(tile_r) * SA_R + int'(row_cnt)) * DIM + int'(tile_c) * SA_C;
   end

   always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
      if (I_ASYN_RST) begin
         state       <= IDLE;
         row_cnt     <= '0;
         tile_c      <= '0;
         tile_r      <= '0;
         O_TILE_DONE <= 1'b0;
      end else begin
         state       <= state_nxt;
         O_TILE_DONE <= accept && row_last;
         if (I_START) begin
            row_cnt <= '0;
            tile_c  <= '0;
            tile_r  <= '0;
         end else if (accept) begin
            row_cnt <= row_last ? '0 : row_cnt + 1'b1;
            if (row_last) begin
               tile_c <= tc_last ? '0 : tile_c + 1'b1;
               if (tc_last)
                  tile_r <= tr_last ? '0 : tile_r + 1'b1;
            end
         end
      end
   end

   // Score storage is never cleared by I_START; consumers qualify with O_DATA_VLD
   always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
      if (I_ASYN_RST)
         O_SCORE <= '0;
      else if (accept)
         for (int j = 0; j < SA_C; j++)
            O_SCORE[(wr_base + j)*D_W +: D_W] <= scaled[j*D_W +: D_W];
   end
endmodule

// File: tb/tb_sa_score_collector.sv
// tb_sa_score_collector: directed self-checking bench for sa_score_collector.
module tb_sa_score_collector;
   localparam int D_W = 16, SA_R = 16, SA_C = 16, DIM = 64, SHIFT = 3;
   localparam int NROWS = DIM * DIM / SA_C;

   logic I_CLK = 1'b0, I_ASYN_RST = 1'b1, I_START = 1'b0, I_ROW_VLD = 1'b0;
   logic [SA_C*D_W-1:0] I_ROW = '0;
   logic O_ROW_RDY, O_TILE_DONE, O_DATA_VLD;
   logic [DIM*DIM*D_W-1:0] O_SCORE;

   sa_score_collector #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .DIM(DIM), .SHIFT(SHIFT)) dut (
      .I_CLK(I_CLK), .I_ASYN_RST(I_ASYN_RST), .I_START(I_START), .I_ROW_VLD(I_ROW_VLD),
      .I_ROW(I_ROW), .O_ROW_RDY(O_ROW_RDY), .O_TILE_DONE(O_TILE_DONE),
      .O_DATA_VLD(O_DATA_VLD), .O_SCORE(O_SCORE)
   );

   always #5 I_CLK = ~I_CLK;

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge I_CLK);
      #1;
   endtask

   // mode 0: r*8, 1: (r*64+c)*8, 2: 8, 3: 16
   function automatic logic [D_W-1:0] row_in(input int mode, input int r, input int c);
      case (mode)
         0: return D_W'(r * 8);
         1: return D_W'((r * 64 + c) * 8);
         2: return D_W'(8);
         default: return D_W'(16);
      endcase
   endfunction

   function automatic logic [D_W-1:0] exp_out(input int mode, input int r, input int c);
      case (mode)
         0: return D_W'(r);
         1: return D_W'(r * 64 + c);
         2: return D_W'(1);
         3: return D_W'(2);
         default: return '0;
      endcase
   endfunction

   function automatic logic [D_W-1:0] elem(input int r, input int c);
      return O_SCORE[(r*DIM+c)*D_W +: D_W];
   endfunction

   task automatic fill(input int mode, input int k);
      int tile, r, tc;
      tile = k / SA_R;
      tc   = tile % (DIM / SA_C);
      r    = (tile / (DIM / SA_C)) * SA_R + k % SA_R;
      for (int j = 0; j < SA_C; j++)
         I_ROW[j*D_W +: D_W] = row_in(mode, r, tc * SA_C + j);
   endtask

   task automatic check_matrix(input string tag, input int mode);
      int bad = 0;
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++)
            if (elem(r, c) !== exp_out(mode, r, c)) bad++;
      chk(tag, bad, 0);
   endtask

   task automatic start(input logic vld);
      I_START   = 1'b1;
      I_ROW_VLD = vld;
      step();
      I_START   = 1'b0;
      I_ROW_VLD = 1'b0;
   endtask

   task automatic send_rows(input string tag, input int mode, input int n, input bit gaps,
                            output int tiles, output bit early);
      int acc = 0, cyc = 0;
      logic v, rdy;
      tiles = 0;
      early = 0;
      while (acc < n && cyc < 4000) begin
         v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         I_ROW_VLD = v;
         fill(mode, acc);
         rdy = O_ROW_RDY;
         step();
         if (v && rdy) acc++;
         cyc++;
         tiles += int'(O_TILE_DONE);
         if (O_DATA_VLD && acc < NROWS) early = 1;
      end
      I_ROW_VLD = 1'b0;
      chk({tag, "_rows"}, acc, n);
   endtask

   logic [D_W-1:0] e_pos, e_neg, e_max, e_min, e_m1;
   int tiles;
   bit early;

   initial begin
`ifdef SCORE_ROUND_EN
      e_pos = 16'h0003; e_neg = 16'hFFFE; e_max = 16'h1000; e_min = 16'hF000; e_m1 = 16'h0000;
`else
      e_pos = 16'h0002; e_neg = 16'hFFFD; e_max = 16'h0FFF; e_min = 16'hF000; e_m1 = 16'hFFFF;
`endif
      #12;
      chk("rst_rdy", O_ROW_RDY, 0);
      chk("rst_tile_done", O_TILE_DONE, 0);
      chk("rst_data_vld", O_DATA_VLD, 0);
      check_matrix("rst_matrix", 9);
      I_ASYN_RST = 1'b0;
      // Idle with valid rows offered: nothing accepted
      I_ROW_VLD = 1'b1;
      for (int j = 0; j < SA_C; j++) I_ROW[j*D_W +: D_W] = 16'h0100;
      repeat (3) step();
      chk("idle_rdy", O_ROW_RDY, 0);
      chk("idle_data_vld", O_DATA_VLD, 0);
      check_matrix("idle_matrix", 9);
      // Tie: row offered with I_START is dropped; next row lands at (0,0)
      for (int j = 0; j < SA_C; j++) I_ROW[j*D_W +: D_W] = 16'h0200;
      start(1'b1);
      chk("rdy_after_start", O_ROW_RDY, 1);
      I_ROW[0*D_W +: D_W] = 16'h0014;
      I_ROW[1*D_W +: D_W] = 16'hFFEC;
      I_ROW[2*D_W +: D_W] = 16'h7FFF;
      I_ROW[3*D_W +: D_W] = 16'h8000;
      I_ROW[4*D_W +: D_W] = 16'hFFFF;
      for (int j = 5; j < SA_C; j++) I_ROW[j*D_W +: D_W] = 16'h0100;
      I_ROW_VLD = 1'b1;
      step();
      I_ROW_VLD = 1'b0;
      chk("scale_0014", elem(0, 0), e_pos);
      chk("scale_ffec", elem(0, 1), e_neg);
      chk("scale_7fff", elem(0, 2), e_max);
      chk("scale_8000", elem(0, 3), e_min);
      chk("scale_ffff", elem(0, 4), e_m1);
      chk("scale_0100", elem(0, 5), 16'h0020);
      chk("tie_row1_untouched", elem(1, 0), 0);
      // Gap-free full pass
      start(1'b0);
      send_rows("full", 0, NROWS, 0, tiles, early);
      chk("full_tiles", tiles, 16);
      chk("full_vld_early", early, 0);
      chk("full_data_vld", O_DATA_VLD, 1);
      chk("full_last_tile_done", O_TILE_DONE, 1);
      check_matrix("full_matrix", 0);
      step();
      chk("done_tile_done_low", O_TILE_DONE, 0);
      chk("done_vld_hold", O_DATA_VLD, 1);
      chk("done_rdy", O_ROW_RDY, 0);
      // Pass with random gaps and per-column data
      start(1'b0);
      chk("vld_drop_on_start", O_DATA_VLD, 0);
      send_rows("gap", 1, NROWS, 1, tiles, early);
      chk("gap_tiles", tiles, 16);
      chk("gap_vld_early", early, 0);
      chk("gap_data_vld", O_DATA_VLD, 1);
      check_matrix("gap_matrix", 1);
      // Abort after 100 rows, then a full fresh pass
      start(1'b0);
      send_rows("abort", 3, 100, 0, tiles, early);
      chk("abort_vld_early", early, 0);
      chk("abort_data_vld", O_DATA_VLD, 0);
      chk("abort_partial", elem(0, 0), 16'h0002);
      start(1'b0);
      send_rows("restart", 2, NROWS, 0, tiles, early);
      chk("restart_data_vld", O_DATA_VLD, 1);
      chk("restart_tiles", tiles, 16);
      check_matrix("restart_matrix", 2);
      // Async reset right as a tile completes
      start(1'b0);
      send_rows("prerst", 0, SA_R, 0, tiles, early);
      chk("prerst_tile_done", O_TILE_DONE, 1);
      I_ASYN_RST = 1'b1;
      #2;
      chk("arst_rdy", O_ROW_RDY, 0);
      chk("arst_tile_done", O_TILE_DONE, 0);
      chk("arst_data_vld", O_DATA_VLD, 0);
      check_matrix("arst_matrix", 9);
      I_ASYN_RST = 1'b0;
      step();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
